// File: rtl/relu_act_pipe.sv
// Multi-lane, two-stage activation pipeline (bypass / ReLU / leaky / clip) with
// a valid/ready handshake and a saturating count of activation-zeroed lanes.

module relu_act_lane #(
  parameter int DATA_W      = 32,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [DATA_W-1:0] x,
  input  logic              neg,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] clip,
  output logic [DATA_W-1:0] y,
  output logic              zeroed
);
  localparam logic [1:0] MODE_RELU  = 2'b01;
  localparam logic [1:0] MODE_LEAKY = 2'b10;
  localparam logic [1:0] MODE_CLIP  = 2'b11;

  always_comb begin
    y      = x;
    zeroed = 1'b0;
    case (mode)
      MODE_RELU: begin
        if (neg) begin
          y      = '0;
          zeroed = 1'b1;
        end
      end
      MODE_LEAKY: begin
        if (neg) y = $signed(x) >>> LEAKY_SHIFT;
      end
      MODE_CLIP: begin
        // A negative ceiling collapses every lane to zero, and each one counts.
        if (neg || clip[DATA_W-1]) begin
          y      = '0;
          zeroed = 1'b1;
        end else if ($signed(x) > $signed(clip)) begin
          y = clip;
        end
      end
      default: ;
    endcase
  end
endmodule

module relu_act_pipe #(
  parameter int DATA_W      = 32,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              in_mode,
  input  logic [DATA_W-1:0]       clip_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        zero_cnt,
  input  logic                    cnt_clr
);
  localparam int ZW = $clog2(LANES + 1);
  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  lane_vec_t         in_vec;
  lane_vec_t         s1_data_q, s1_data_d;
  logic [LANES-1:0]  s1_neg_q, s1_neg_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0] s1_clip_q, s1_clip_d;
  logic              s1_valid_q, s1_valid_d;

  lane_vec_t         lane_y;
  logic [LANES-1:0]  lane_zero;
  logic [ZW-1:0]     zeros_now;

  lane_vec_t         out_data_q, out_data_d;
  logic [ZW-1:0]     s2_zeros_q, s2_zeros_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;
  logic [CNT_W:0]    cnt_sum;

  logic s1_adv, s2_adv, out_fire;

  assign in_vec    = in_data;
  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_fire  = s2_valid_q && out_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign zero_cnt  = zero_cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_act_lane #(.DATA_W(DATA_W), .LEAKY_SHIFT(LEAKY_SHIFT)) u_lane (
      .x      (s1_data_q[i]),
      .neg    (s1_neg_q[i]),
      .mode   (s1_mode_q),
      .clip   (s1_clip_q),
      .y      (lane_y[i]),
      .zeroed (lane_zero[i])
    );
  end

  always_comb begin
    zeros_now = '0;
    for (int i = 0; i < LANES; i++) zeros_now = zeros_now + ZW'(lane_zero[i]);
  end

  // Stage 1: capture the beat with its mode, ceiling and lane signs.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_neg_d   = s1_neg_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_vec;
        s1_mode_d = in_mode;
        s1_clip_d = clip_val;
        for (int i = 0; i < LANES; i++) s1_neg_d[i] = in_vec[i][DATA_W-1];
      end
    end
  end

  // Stage 2: register activated lanes; held untouched while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    s2_zeros_d = s2_zeros_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = lane_y;
        s2_zeros_d = zeros_now;
      end
    end
  end

  assign cnt_sum = {1'b0, zero_cnt_q} + {{(CNT_W+1-ZW){1'b0}}, s2_zeros_q};

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (cnt_clr)       zero_cnt_d = '0;
    else if (out_fire) zero_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_neg_q   <= '0;
      s1_mode_q  <= '0;
      s1_clip_q  <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      s2_zeros_q <= '0;
      zero_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_neg_q   <= s1_neg_d;
      s1_mode_q  <= s1_mode_d;
      s1_clip_q  <= s1_clip_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      s2_zeros_q <= s2_zeros_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end
endmodule

// File: tb/tb_relu_act_pipe.sv
// Directed bench for relu_act_pipe: reset, each activation mode, back-pressure,
// counter saturation / clear priority and mid-stream reset.

module tb_relu_act_pipe;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   in_mode;
  logic [31:0]  clip_val;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  zero_cnt;
  logic         cnt_clr;

  int checks = 0;
  int errors = 0;

  relu_act_pipe #(.DATA_W(32), .LANES(4), .LEAKY_SHIFT(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .clip_val(clip_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .zero_cnt(zero_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] bp_beat(input int i);
    logic [31:0] a;
    a = 32'(i);
    return {a + 32'd1, 32'd0 - (a + 32'd1), a * 32'd3, 32'hA500_0000 + a};
  endfunction

  // Presents one beat, returns out_valid one cycle after capture and the
  // output seen two cycles after capture; the handshake lands on the next edge.
  task automatic run_beat(input logic [127:0] d, input logic [1:0] m, input logic [31:0] c,
                          output logic v_early, output logic v, output logic [127:0] q);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mode = m; clip_val = c; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    v_early = out_valid;
    @(negedge clk);
    v = out_valid; q = out_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = {4{32'hFFFF_FFFF}}; in_mode = 2'b01;
    clip_val = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (zero_cnt !== 16'd0) begin errors++; $display("FAIL reset_zero_cnt got %0d want 0", zero_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    end
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture out_valid got %b want 0", out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_relu();
    logic ve, v; logic [127:0] q;
    run_beat({32'hFFFF_FFFB, 32'd0, 32'd7, 32'h8000_0000}, 2'b01, 32'd0, ve, v, q);
    checks++; if (ve !== 1'b0) begin errors++; $display("FAIL relu_latency_early got %b want 0", ve); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL relu_valid got %b want 1", v); end
    checks++; if (q !== {32'd0, 32'd0, 32'd7, 32'd0}) begin errors++; $display("FAIL relu_data got %h want %h", q, {32'd0, 32'd0, 32'd7, 32'd0}); end
    @(negedge clk);
    checks++; if (zero_cnt !== 16'd2) begin errors++; $display("FAIL relu_zero_cnt got %0d want 2", zero_cnt); end
  endtask

  task automatic test_leaky_clip();
    logic ve, v; logic [127:0] q;
    run_beat({32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFF7}, 2'b10, 32'd0, ve, v, q);
    checks++; if (q !== {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFFE}) begin errors++; $display("FAIL leaky_data got %h", q); end
    @(negedge clk);
    checks++; if (zero_cnt !== 16'd2) begin errors++; $display("FAIL leaky_zero_cnt got %0d want 2", zero_cnt); end
    run_beat({32'hFFFF_FFFD, 32'd5, 32'd6, 32'd100}, 2'b11, 32'd6, ve, v, q);
    checks++; if (q !== {32'd0, 32'd5, 32'd6, 32'd6}) begin errors++; $display("FAIL clip_data got %h want %h", q, {32'd0, 32'd5, 32'd6, 32'd6}); end
    @(negedge clk);
    checks++; if (zero_cnt !== 16'd3) begin errors++; $display("FAIL clip_zero_cnt got %0d want 3", zero_cnt); end
    run_beat({32'hFFFF_FFFD, 32'd5, 32'd0, 32'd9}, 2'b11, 32'hFFFF_FFFF, ve, v, q);
    checks++; if (q !== 128'd0) begin errors++; $display("FAIL clip_neg_ceiling_data got %h want 0", q); end
    @(negedge clk);
    checks++; if (zero_cnt !== 16'd7) begin errors++; $display("FAIL clip_neg_ceiling_cnt got %0d want 7", zero_cnt); end
    run_beat({32'hFFFF_FFFD, 32'd5, 32'h8000_0000, 32'd9}, 2'b00, 32'd0, ve, v, q);
    checks++; if (q !== {32'hFFFF_FFFD, 32'd5, 32'h8000_0000, 32'd9}) begin errors++; $display("FAIL bypass_data got %h", q); end
    @(negedge clk);
    checks++; if (zero_cnt !== 16'd7) begin errors++; $display("FAIL bypass_zero_cnt got %0d want 7", zero_cnt); end
  endtask

  task automatic test_back_to_back();
    int tx = 0, rx = 0;
    bit prev_stall = 1'b0, saw_block = 1'b0;
    logic [127:0] prev_q = '0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (tx < 8);
      in_data   = bp_beat(tx);
      in_mode   = 2'b00;
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_q) begin
          errors++; $display("FAIL bp_hold got v=%b %h want v=1 %h", out_valid, out_data, prev_q);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== bp_beat(rx)) begin errors++; $display("FAIL bp_order beat %0d got %h want %h", rx, out_data, bp_beat(rx)); end
        rx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_q = out_data;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rx != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rx); end
    checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL bp_in_ready_block got %b want 1", saw_block); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got %b want 0", out_valid); end
    end
  endtask

  task automatic test_counter();
    logic ve, v; logic [127:0] q;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    checks++; if (zero_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", zero_cnt); end
    out_ready = 1'b1; in_mode = 2'b01; in_data = {4{32'hFFFF_FFFF}};
    for (int i = 0; i < 16383; i++) begin
      @(negedge clk); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (zero_cnt !== 16'd65532) begin errors++; $display("FAIL cnt_preload got %0d want 65532", zero_cnt); end
    run_beat({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1}, 2'b01, 32'd0, ve, v, q);
    @(negedge clk);
    checks++; if (zero_cnt !== 16'd65534) begin errors++; $display("FAIL cnt_near_max got %0d want 65534", zero_cnt); end
    run_beat({4{32'h8000_0000}}, 2'b01, 32'd0, ve, v, q);
    @(negedge clk);
    checks++; if (zero_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got %0d want 65535", zero_cnt); end
    run_beat({4{32'hFFFF_FFF0}}, 2'b01, 32'd0, ve, v, q);
    @(negedge clk);
    checks++; if (zero_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_stick got %0d want 65535", zero_cnt); end
    run_beat({4{32'hFFFF_FFF0}}, 2'b01, 32'd0, ve, v, q);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL cnt_clr_beat_valid got %b want 1", v); end
    cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    checks++; if (zero_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr_wins got %0d want 0", zero_cnt); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_data = bp_beat(20);
    @(negedge clk); in_data = bp_beat(21);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_drop got %b want 0", out_valid); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL midrst_out_data got %h want 0", out_data); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_beat got %b want 0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky_clip();
    test_back_to_back();
    test_counter();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
